// File: rtl/vs_rf_pkg.sv
// Shared types, default dimensions and reset/clear presets for the vector/scalar register file.
package vs_rf_pkg;

  localparam int DEF_LANES = 16;
  localparam int DEF_NREGS = 16;
  localparam int DEF_W     = 32;

  typedef enum logic [1:0] {
    WM_VEC   = 2'd0,
    WM_SCA   = 2'd1,
    WM_BCAST = 2'd2,
    WM_NONE  = 2'd3
  } wmode_e;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  // Preset of the scalar-aliased lane of vector register idx; every other lane presets to zero.
  function automatic logic [31:0] presetLane(input int nregs, input int idx);
    if (idx == nregs - 1) return 32'd1;
    if (idx == nregs - 2) return 32'd16;
    if (idx == nregs - 4) return 32'd48;
    if (idx == nregs - 5) return 32'd82;
    return 32'd0;
  endfunction

endpackage

// File: rtl/vs_regfile_p_if.sv
// Read/write/issue/clear bus of the register file; master drives requests, slave returns data.
interface vs_regfile_p_if #(
  parameter int LANES = 16,
  parameter int NREGS = 16,
  parameter int W     = 32,
  parameter int AW    = $clog2(NREGS)
);

  logic [AW-1:0]             ra1;
  logic [AW-1:0]             ra2;
  logic                      sel_v;
  logic [LANES-1:0][W-1:0]   rd1;
  logic [LANES-1:0][W-1:0]   rd2;
  logic                      we;
  logic [AW-1:0]             wa;
  logic [1:0]                wmode;
  logic [LANES-1:0]          wmask;
  logic [LANES-1:0][W-1:0]   wd;
  logic [W-1:0]              pc_in;
  logic                      iss_v;
  logic                      iss_bank;
  logic [AW-1:0]             iss_rd;
  logic                      pend1;
  logic                      pend2;
  logic                      clr_start;
  logic                      clr_busy;

  modport master (
    output ra1, ra2, sel_v, we, wa, wmode, wmask, wd, pc_in,
           iss_v, iss_bank, iss_rd, clr_start,
    input  rd1, rd2, pend1, pend2, clr_busy
  );

  modport slave (
    input  ra1, ra2, sel_v, we, wa, wmode, wmask, wd, pc_in,
           iss_v, iss_bank, iss_rd, clr_start,
    output rd1, rd2, pend1, pend2, clr_busy
  );

endinterface

// File: rtl/vs_rf_scoreboard.sv
// Pending-producer bits for both banks; a same-cycle set overrides a clear of the same entry.
module vs_rf_scoreboard #(
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_i,
  input  logic          setBank_i,
  input  logic [AW-1:0] setIdx_i,
  input  logic          clr_i,
  input  logic          clrBank_i,
  input  logic [AW-1:0] clrIdx_i,
  input  logic          lookBank_i,
  input  logic [AW-1:0] lookIdx1_i,
  input  logic [AW-1:0] lookIdx2_i,
  output logic          pend1_o,
  output logic          pend2_o
);

  logic [1:0][NREGS-1:0] pending_q;

  // The set is assigned last so it takes priority when both hit the same entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      if (clr_i) pending_q[clrBank_i][clrIdx_i] <= 1'b0;
      if (set_i) pending_q[setBank_i][setIdx_i] <= 1'b1;
    end
  end

  assign pend1_o = pending_q[lookBank_i][lookIdx1_i];
  assign pend2_o = pending_q[lookBank_i][lookIdx2_i];

endmodule

// File: rtl/vs_regfile_p.sv
// Vector/scalar register file: two bypassed read ports, one masked/scalar/broadcast write port,
// pending scoreboard and a sequential clear engine that reloads the vector bank presets.
module vs_regfile_p
  import vs_rf_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int NREGS = DEF_NREGS,
  parameter int W     = DEF_W
) (
  input logic           clk,
  input logic           rst,
  vs_regfile_p_if.slave bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] PC_ADDR = AW'(NREGS - 1);

  typedef logic [LANES-1:0][W-1:0] vec_t;

  vec_t          vecMem_q [NREGS];
  logic [W-1:0]  scaMem_q [NREGS-1];
  clr_state_e    clrState_q;
  logic [AW-1:0] clrIdx_q;
  logic          clrBusy_q;

  wmode_e           wrMode;
  logic             wrEn;
  logic             vecWe;
  logic             scaWe;
  logic [LANES-1:0] laneWe;
  vec_t             wrData;
  logic [AW-1:0]    raAddr [2];
  vec_t             rdData [2];

  function automatic vec_t presetVec(input int idx);
    vec_t v;
    v = '0;
    v[LANES-1] = W'(presetLane(NREGS, idx));
    return v;
  endfunction

  // Decode the write port into per-bank enables; broadcast replicates the scalar lane.
  always_comb begin
    wrMode = wmode_e'(bus.wmode);
    wrEn   = bus.we && !clrBusy_q;
    vecWe  = 1'b0;
    scaWe  = 1'b0;
    laneWe = '0;
    wrData = bus.wd;
    case (wrMode)
      WM_VEC: begin
        vecWe  = wrEn;
        laneWe = bus.wmask;
      end
      WM_SCA: begin
        scaWe = wrEn && (bus.wa != PC_ADDR);
      end
      WM_BCAST: begin
        vecWe  = wrEn;
        laneWe = '1;
        wrData = {LANES{bus.wd[LANES-1]}};
      end
      default: ;
    endcase
  end

  // Clear engine owns the vector bank while running, so the write port is gated above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) vecMem_q[r] <= presetVec(r);
      for (int r = 0; r < NREGS - 1; r++) scaMem_q[r] <= '0;
    end else begin
      if (clrState_q == CLR_RUN) begin
        vecMem_q[clrIdx_q] <= presetVec(int'(clrIdx_q));
      end else if (vecWe) begin
        for (int l = 0; l < LANES; l++) begin
          if (laneWe[l]) vecMem_q[bus.wa][l] <= wrData[l];
        end
      end
      if (scaWe) scaMem_q[bus.wa] <= bus.wd[LANES-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clrState_q <= CLR_IDLE;
      clrIdx_q   <= '0;
      clrBusy_q  <= 1'b0;
    end else begin
      case (clrState_q)
        CLR_IDLE: begin
          if (bus.clr_start) begin
            clrState_q <= CLR_RUN;
            clrIdx_q   <= '0;
            clrBusy_q  <= 1'b1;
          end
        end
        CLR_RUN: begin
          if (clrIdx_q == PC_ADDR) begin
            clrState_q <= CLR_IDLE;
            clrBusy_q  <= 1'b0;
          end else begin
            clrIdx_q <= clrIdx_q + 1'b1;
          end
        end
        default: begin
          clrState_q <= CLR_IDLE;
          clrBusy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign raAddr[0] = bus.ra1;
  assign raAddr[1] = bus.ra2;

  // A scalar read takes its lower lanes from the vector bank and its top lane from the scalar bank or pc.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdData[p] = vecMem_q[raAddr[p]];
      if (bus.sel_v) begin
        if (vecWe && (bus.wa == raAddr[p])) begin
          for (int l = 0; l < LANES; l++) begin
            if (laneWe[l]) rdData[p][l] = wrData[l];
          end
        end
      end else begin
        if (raAddr[p] == PC_ADDR) begin
          rdData[p][LANES-1] = bus.pc_in;
        end else if (scaWe && (bus.wa == raAddr[p])) begin
          rdData[p][LANES-1] = bus.wd[LANES-1];
        end else begin
          rdData[p][LANES-1] = scaMem_q[raAddr[p]];
        end
      end
    end
  end

  assign bus.rd1      = rdData[0];
  assign bus.rd2      = rdData[1];
  assign bus.clr_busy = clrBusy_q;

  vs_rf_scoreboard #(
    .NREGS(NREGS),
    .AW   (AW)
  ) uScoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_i     (bus.iss_v),
    .setBank_i (bus.iss_bank),
    .setIdx_i  (bus.iss_rd),
    .clr_i     (wrEn && (wrMode != WM_NONE)),
    .clrBank_i (wrMode != WM_SCA),
    .clrIdx_i  (bus.wa),
    .lookBank_i(bus.sel_v),
    .lookIdx1_i(bus.ra1),
    .lookIdx2_i(bus.ra2),
    .pend1_o   (bus.pend1),
    .pend2_o   (bus.pend2)
  );

endmodule

// File: tb/tb_vs_regfile_p.sv
// Directed bench for vs_regfile_p: reset presets, write modes with bypass, scoreboard and clear engine.
module tb_vs_regfile_p;

  typedef logic [15:0][31:0] vec_t;

  logic clk;
  logic rst;
  int   nCompared   = 0;
  int   nMismatched = 0;

  vs_regfile_p_if bus ();

  vs_regfile_p dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idleInputs();
    bus.ra1       = '0;
    bus.ra2       = '0;
    bus.sel_v     = 1'b0;
    bus.we        = 1'b0;
    bus.wa        = '0;
    bus.wmode     = 2'd0;
    bus.wmask     = '0;
    bus.wd        = '0;
    bus.pc_in     = '0;
    bus.iss_v     = 1'b0;
    bus.iss_bank  = 1'b0;
    bus.iss_rd    = '0;
    bus.clr_start = 1'b0;
  endtask

  task automatic test_reset();
    vec_t exp;
    rst = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.sel_v = 1'b1; bus.ra1 = 4'd15; bus.ra2 = 4'd12;
    #1;
    exp = '0; exp[15] = 32'd1;
    nCompared++;
    if (bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL reset_vreg15 got %h want %h", bus.rd1, exp);
    end
    exp = '0; exp[15] = 32'd48;
    nCompared++;
    if (bus.rd2 !== exp) begin
      nMismatched++; $display("[TB] FAIL reset_vreg12 got %h want %h", bus.rd2, exp);
    end
    bus.ra1 = 4'd14; bus.ra2 = 4'd11;
    #1;
    exp = '0; exp[15] = 32'd16;
    nCompared++;
    if (bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL reset_vreg14 got %h want %h", bus.rd1, exp);
    end
    exp = '0; exp[15] = 32'd82;
    nCompared++;
    if (bus.rd2 !== exp) begin
      nMismatched++; $display("[TB] FAIL reset_vreg11 got %h want %h", bus.rd2, exp);
    end
    bus.sel_v = 1'b0; bus.ra1 = 4'd3;
    #1;
    nCompared++;
    if (bus.rd1 !== vec_t'('0)) begin
      nMismatched++; $display("[TB] FAIL reset_sreg3 got %h want 0", bus.rd1);
    end
    nCompared++;
    if (bus.clr_busy !== 1'b0 || bus.pend1 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL reset_busy_pend got busy=%b pend=%b want 0/0", bus.clr_busy, bus.pend1);
    end
  endtask

  task automatic test_masked_write();
    vec_t exp;
    @(negedge clk);
    idleInputs();
    bus.we = 1'b1; bus.wmode = 2'd0; bus.wa = 4'd2; bus.wmask = 16'h0003;
    for (int i = 0; i < 16; i++) bus.wd[i] = 32'hA000_0000 + i;
    bus.wd[0] = 32'd5; bus.wd[1] = 32'd7;
    bus.sel_v = 1'b1; bus.ra1 = 4'd2; bus.ra2 = 4'd3;
    #1;
    exp = '0; exp[0] = 32'd5; exp[1] = 32'd7;
    nCompared++;
    if (bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL masked_bypass got %h want %h", bus.rd1, exp);
    end
    nCompared++;
    if (bus.rd2 !== vec_t'('0)) begin
      nMismatched++; $display("[TB] FAIL masked_other_port got %h want 0", bus.rd2);
    end
    @(negedge clk);
    idleInputs();
    bus.sel_v = 1'b1; bus.ra1 = 4'd2;
    #1;
    nCompared++;
    if (bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL masked_stored got %h want %h", bus.rd1, exp);
    end
  endtask

  task automatic test_broadcast_scalar();
    vec_t exp;
    @(negedge clk);
    idleInputs();
    bus.we = 1'b1; bus.wmode = 2'd2; bus.wa = 4'd4;
    for (int i = 0; i < 16; i++) bus.wd[i] = 32'h1111_0000 + i;
    bus.wd[15] = 32'd9;
    bus.sel_v = 1'b1; bus.ra1 = 4'd4;
    #1;
    for (int i = 0; i < 16; i++) exp[i] = 32'd9;
    nCompared++;
    if (bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL bcast_bypass got %h want %h", bus.rd1, exp);
    end
    @(negedge clk);
    idleInputs();
    bus.sel_v = 1'b1; bus.ra1 = 4'd4;
    #1;
    nCompared++;
    if (bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL bcast_stored got %h want %h", bus.rd1, exp);
    end
    bus.sel_v = 1'b0;
    #1;
    exp[15] = 32'd0;
    nCompared++;
    if (bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL scalar_view_reg4 got %h want %h", bus.rd1, exp);
    end
    @(negedge clk);
    idleInputs();
    bus.we = 1'b1; bus.wmode = 2'd1; bus.wa = 4'd3;
    for (int i = 0; i < 16; i++) bus.wd[i] = 32'hBEEF_0000 + i;
    bus.wd[15] = 32'd33;
    bus.sel_v = 1'b0; bus.ra1 = 4'd3;
    #1;
    exp = '0; exp[15] = 32'd33;
    nCompared++;
    if (bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL scalar_bypass got %h want %h", bus.rd1, exp);
    end
    @(negedge clk);
    idleInputs();
    bus.sel_v = 1'b1; bus.ra1 = 4'd3;
    #1;
    nCompared++;
    if (bus.rd1 !== vec_t'('0)) begin
      nMismatched++; $display("[TB] FAIL scalar_leaves_vector got %h want 0", bus.rd1);
    end
    @(negedge clk);
    idleInputs();
    bus.we = 1'b1; bus.wmode = 2'd1; bus.wa = 4'd15; bus.wd[15] = 32'd55;
    bus.sel_v = 1'b0; bus.ra1 = 4'd15; bus.pc_in = 32'd100;
    #1;
    nCompared++;
    if (bus.rd1[15] !== 32'd100) begin
      nMismatched++; $display("[TB] FAIL pc_no_bypass got %0d want 100", bus.rd1[15]);
    end
    @(negedge clk);
    idleInputs();
    bus.sel_v = 1'b0; bus.ra1 = 4'd15; bus.pc_in = 32'd100;
    #1;
    nCompared++;
    if (bus.rd1[15] !== 32'd100) begin
      nMismatched++; $display("[TB] FAIL pc_alias got %0d want 100", bus.rd1[15]);
    end
    @(negedge clk);
    idleInputs();
    bus.we = 1'b1; bus.wmode = 2'd3; bus.wa = 4'd5; bus.wmask = '1; bus.wd = '1;
    bus.sel_v = 1'b1; bus.ra1 = 4'd5;
    #1;
    nCompared++;
    if (bus.rd1 !== vec_t'('0)) begin
      nMismatched++; $display("[TB] FAIL reserved_bypass got %h want 0", bus.rd1);
    end
    @(negedge clk);
    idleInputs();
    bus.sel_v = 1'b1; bus.ra1 = 4'd5;
    #1;
    nCompared++;
    if (bus.rd1 !== vec_t'('0)) begin
      nMismatched++; $display("[TB] FAIL reserved_stored got %h want 0", bus.rd1);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idleInputs();
    bus.iss_v = 1'b1; bus.iss_bank = 1'b1; bus.iss_rd = 4'd6;
    @(negedge clk);
    idleInputs();
    bus.sel_v = 1'b1; bus.ra1 = 4'd6; bus.ra2 = 4'd7;
    #1;
    nCompared++;
    if (bus.pend1 !== 1'b1 || bus.pend2 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL issue_vec6 got pend1=%b pend2=%b want 1/0", bus.pend1, bus.pend2);
    end
    bus.sel_v = 1'b0;
    #1;
    nCompared++;
    if (bus.pend1 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL issue_bank_sel got %b want 0", bus.pend1);
    end
    @(negedge clk);
    idleInputs();
    bus.iss_v = 1'b1; bus.iss_bank = 1'b1; bus.iss_rd = 4'd6;
    bus.we = 1'b1; bus.wmode = 2'd0; bus.wa = 4'd6; bus.wmask = 16'h0001; bus.wd[0] = 32'd3;
    @(negedge clk);
    idleInputs();
    bus.sel_v = 1'b1; bus.ra1 = 4'd6;
    #1;
    nCompared++;
    if (bus.pend1 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL set_wins got %b want 1", bus.pend1);
    end
    @(negedge clk);
    idleInputs();
    bus.we = 1'b1; bus.wmode = 2'd2; bus.wa = 4'd6; bus.wd[15] = 32'd4;
    @(negedge clk);
    idleInputs();
    bus.sel_v = 1'b1; bus.ra1 = 4'd6;
    #1;
    nCompared++;
    if (bus.pend1 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL write_clears got %b want 0", bus.pend1);
    end
    @(negedge clk);
    idleInputs();
    bus.iss_v = 1'b1; bus.iss_bank = 1'b1; bus.iss_rd = 4'd7;
    @(negedge clk);
    idleInputs();
    bus.iss_v = 1'b1; bus.iss_bank = 1'b0; bus.iss_rd = 4'd7;
    @(negedge clk);
    idleInputs();
    bus.we = 1'b1; bus.wmode = 2'd1; bus.wa = 4'd7; bus.wd[15] = 32'd70;
    @(negedge clk);
    idleInputs();
    bus.sel_v = 1'b0; bus.ra2 = 4'd7;
    #1;
    nCompared++;
    if (bus.pend2 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL scalar_clear got %b want 0", bus.pend2);
    end
    bus.sel_v = 1'b1;
    #1;
    nCompared++;
    if (bus.pend2 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL scalar_clear_bank got %b want 1", bus.pend2);
    end
  endtask

  task automatic test_clear();
    vec_t exp;
    int   busyCnt;
    int   k;
    @(negedge clk);
    idleInputs();
    bus.we = 1'b1; bus.wmode = 2'd0; bus.wa = 4'd14; bus.wmask = 16'h8000; bus.wd[15] = 32'd77;
    @(negedge clk);
    idleInputs();
    bus.sel_v = 1'b1; bus.ra1 = 4'd14;
    #1;
    nCompared++;
    if (bus.rd1[15] !== 32'd77) begin
      nMismatched++; $display("[TB] FAIL scribble_reg14 got %0d want 77", bus.rd1[15]);
    end
    @(negedge clk);
    idleInputs();
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    busyCnt = 0;
    k = 0;
    while (bus.clr_busy === 1'b1 && k < 40) begin
      busyCnt++;
      k++;
      if (k == 5) begin
        bus.we = 1'b1; bus.wmode = 2'd2; bus.wa = 4'd0; bus.wd[15] = 32'd123;
      end
      if (k == 6) bus.we = 1'b0;
      if (k == 8) bus.clr_start = 1'b1;
      if (k == 9) bus.clr_start = 1'b0;
      @(negedge clk);
    end
    idleInputs();
    nCompared++;
    if (busyCnt != 16) begin
      nMismatched++; $display("[TB] FAIL clear_busy_cycles got %0d want 16", busyCnt);
    end
    @(negedge clk);
    nCompared++;
    if (bus.clr_busy !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL clear_stays_idle got %b want 0", bus.clr_busy);
    end
    bus.sel_v = 1'b1; bus.ra1 = 4'd14; bus.ra2 = 4'd0;
    #1;
    exp = '0; exp[15] = 32'd16;
    nCompared++;
    if (bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL clear_reg14 got %h want %h", bus.rd1, exp);
    end
    nCompared++;
    if (bus.rd2 !== vec_t'('0)) begin
      nMismatched++; $display("[TB] FAIL clear_drop_write got %h want 0", bus.rd2);
    end
    bus.ra1 = 4'd2; bus.ra2 = 4'd4;
    #1;
    nCompared++;
    if (bus.rd1 !== vec_t'('0) || bus.rd2 !== vec_t'('0)) begin
      nMismatched++; $display("[TB] FAIL clear_reg2_reg4 got %h / %h want 0", bus.rd1, bus.rd2);
    end
    bus.ra1 = 4'd7;
    #1;
    nCompared++;
    if (bus.pend1 !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL clear_keeps_pending got %b want 1", bus.pend1);
    end
    bus.sel_v = 1'b0; bus.ra1 = 4'd3;
    #1;
    exp = '0; exp[15] = 32'd33;
    nCompared++;
    if (bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL clear_keeps_scalar got %h want %h", bus.rd1, exp);
    end
  endtask

  task automatic test_reset_mid_clear();
    vec_t exp;
    @(negedge clk);
    idleInputs();
    bus.we = 1'b1; bus.wmode = 2'd0; bus.wa = 4'd13; bus.wmask = 16'h8000; bus.wd[15] = 32'd66;
    @(negedge clk);
    idleInputs();
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    repeat (4) @(negedge clk);
    bus.sel_v = 1'b1; bus.ra1 = 4'd13;
    #1;
    nCompared++;
    if (bus.clr_busy !== 1'b1 || bus.rd1[15] !== 32'd66) begin
      nMismatched++; $display("[TB] FAIL midclear_state got busy=%b reg13=%0d want 1/66", bus.clr_busy, bus.rd1[15]);
    end
    rst = 1'b0;
    #1;
    nCompared++;
    if (bus.clr_busy !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL midclear_busy got %b want 0", bus.clr_busy);
    end
    bus.ra2 = 4'd11;
    #1;
    nCompared++;
    if (bus.rd1 !== vec_t'('0)) begin
      nMismatched++; $display("[TB] FAIL midclear_reg13 got %h want 0", bus.rd1);
    end
    exp = '0; exp[15] = 32'd82;
    nCompared++;
    if (bus.rd2 !== exp) begin
      nMismatched++; $display("[TB] FAIL midclear_reg11 got %h want %h", bus.rd2, exp);
    end
    bus.ra1 = 4'd7;
    #1;
    nCompared++;
    if (bus.pend1 !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL midclear_pending got %b want 0", bus.pend1);
    end
    bus.sel_v = 1'b0; bus.ra1 = 4'd3;
    #1;
    nCompared++;
    if (bus.rd1[15] !== 32'd0) begin
      nMismatched++; $display("[TB] FAIL midclear_scalar got %0d want 0", bus.rd1[15]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.sel_v = 1'b1; bus.ra1 = 4'd14;
    #1;
    exp = '0; exp[15] = 32'd16;
    nCompared++;
    if (bus.clr_busy !== 1'b0 || bus.rd1 !== exp) begin
      nMismatched++; $display("[TB] FAIL after_reset got busy=%b reg14=%h want 0/%h", bus.clr_busy, bus.rd1, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    idleInputs();
    test_reset();
    test_masked_write();
    test_broadcast_scalar();
    test_scoreboard();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
